// File: rtl/arb_pkg.sv
// arb_pkg: shared state encoding and default sizing for the round-robin arbiter.
package arb_pkg;
  typedef enum logic {IDLE, GRANT} arb_state_t;
  localparam int ARB_N = 8;
  localparam int ARB_HOLD_MAX = 16;
endpackage

// File: rtl/priority_decoder.sv
// priority_decoder: index of the lowest set bit of in_vec; valid when any bit is set.
module priority_decoder #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH-1:0]         in_vec,
  output logic [$clog2(WIDTH)-1:0] idx,
  output logic                     valid
);
  localparam int IW = $clog2(WIDTH);
  always_comb begin
    idx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) idx = in_vec[i] ? IW'(i) : idx;
    valid = |in_vec;
  end
endmodule

// File: rtl/rr_arbiter.sv
// rr_arbiter: round-robin arbiter with registered one-hot grant held while the owner requests.
// Define RR_ARB_TIMEOUT_EN to force-release an owner after HOLD_MAX consecutive grant cycles.
module rr_arbiter
  import arb_pkg::*;
#(
  parameter int N        = ARB_N,
  parameter int HOLD_MAX = ARB_HOLD_MAX
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N-1:0]         req,
  output logic [N-1:0]         gnt,
  output logic [$clog2(N)-1:0] gnt_idx,
  output logic                 gnt_valid
);
  localparam int IW = $clog2(N);
  if (N < 2 || (N & (N - 1)) != 0 || HOLD_MAX < 1) begin : g_bad_cfg
    $error("rr_arbiter: N must be a power of two >= 2 and HOLD_MAX >= 1");
  end
  arb_state_t state_q, state_d;
  logic [IW-1:0] owner_q, owner_d, last_q, last_d, pick_ptr, m_idx, u_idx, win_idx;
  logic [N-1:0] gnt_q, gnt_d, owner_bit, pick_req, mask;
  logic m_valid, u_valid, force_rel, rel, take, keep;
  assign owner_bit = {{(N-1){1'b0}}, 1'b1} << owner_q;
`ifdef RR_ARB_TIMEOUT_EN
  localparam int CW = HOLD_MAX > 1 ? $clog2(HOLD_MAX) : 1;
  logic [CW-1:0] cnt_q, cnt_d;
  assign force_rel = state_q == GRANT && req[owner_q] && cnt_q == CW'(HOLD_MAX - 1);
  // Any release that stays in GRANT is an owner change or a re-grant, so it restarts the count.
  assign cnt_d = (state_q != GRANT || state_d != GRANT || rel) ? '0 : cnt_q + 1'b1;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  end
`else
  assign force_rel = 1'b0;
`endif
  always_comb begin
    pick_req = force_rel ? req & ~owner_bit : req;
    pick_ptr = state_q == GRANT ? owner_q : last_q;
    for (int i = 0; i < N; i++) mask[i] = IW'(i) > pick_ptr;
  end
  priority_decoder #(.WIDTH(N)) u_masked (
    .in_vec(pick_req & mask),
    .idx   (m_idx),
    .valid (m_valid)
  );
  priority_decoder #(.WIDTH(N)) u_unmasked (
    .in_vec(pick_req),
    .idx   (u_idx),
    .valid (u_valid)
  );
  always_comb begin
    win_idx = m_valid ? m_idx : u_idx;
    rel     = state_q == GRANT && (!req[owner_q] || force_rel);
    take    = (state_q == IDLE || rel) && u_valid;
    keep    = !take && state_q == GRANT && (!rel || force_rel);
    state_d = (take || keep) ? GRANT : IDLE;
    owner_d = take ? win_idx : (keep ? owner_q : '0);
    last_d  = take ? win_idx : last_q;
    gnt_d   = (take || keep) ? {{(N-1){1'b0}}, 1'b1} << owner_d : '0;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      owner_q <= '0;
      last_q  <= IW'(N - 1);
      gnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      gnt_q   <= gnt_d;
    end
  end
  assign gnt       = gnt_q;
  assign gnt_idx   = owner_q;
  assign gnt_valid = state_q == GRANT;
endmodule

// File: tb/tb_rr_arbiter.sv
// tb_rr_arbiter: table-driven directed check of rr_arbiter with N=8, HOLD_MAX=4.
module tb_rr_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] req = 8'h00;
  logic [7:0] gnt;
  logic [2:0] gnt_idx;
  logic gnt_valid;
  int tests = 0;
  int fails = 0;
  rr_arbiter #(.N(8), .HOLD_MAX(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .gnt      (gnt),
    .gnt_idx  (gnt_idx),
    .gnt_valid(gnt_valid)
  );
  always #5 clk = ~clk;
  typedef struct {
    logic       rst;
    logic [7:0] req;
    logic [2:0] idx;
    logic       vld;
  } vec_t;
  vec_t tbl[$];
  task automatic check(input string name, input logic [2:0] ei, input logic ev);
    logic [7:0] eg;
    eg = ev ? (8'h01 << ei) : 8'h00;
    tests++;
    if (gnt !== eg || gnt_idx !== ei || gnt_valid !== ev) begin
      fails++;
      $display("FAIL %s: got gnt=%b idx=%0d vld=%b, want gnt=%b idx=%0d vld=%b",
               name, gnt, gnt_idx, gnt_valid, eg, ei, ev);
    end
  endtask
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req = 8'h00;
    @(negedge clk);
    rst_n = 1'b1;
  endtask
  task automatic step(input logic [7:0] v);
    req = v;
    @(posedge clk);
    #1;
  endtask
  task automatic add(input logic r, input logic [7:0] q, input logic [2:0] i, input logic v);
    tbl.push_back('{r, q, i, v});
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) add(1'b0, 8'h00, 3'd0, 1'b0);
    add(1'b0, 8'h50, 3'd4, 1'b1);
    for (int i = 0; i < 3; i++) add(1'b0, 8'h50, 3'd4, 1'b1);
    add(1'b0, 8'h40, 3'd6, 1'b1);
    add(1'b0, 8'h00, 3'd0, 1'b0);
    add(1'b1, 8'hFF, 3'd0, 1'b1);
    add(1'b0, 8'hFE, 3'd1, 1'b1);
    add(1'b0, 8'hFD, 3'd2, 1'b1);
    add(1'b0, 8'hFB, 3'd3, 1'b1);
    add(1'b0, 8'hF7, 3'd4, 1'b1);
    add(1'b0, 8'hEF, 3'd5, 1'b1);
    add(1'b0, 8'hDF, 3'd6, 1'b1);
    add(1'b0, 8'hBF, 3'd7, 1'b1);
    add(1'b0, 8'h7F, 3'd0, 1'b1);
    add(1'b0, 8'h80, 3'd7, 1'b1);
    add(1'b0, 8'h82, 3'd7, 1'b1);
    add(1'b0, 8'h02, 3'd1, 1'b1);
    add(1'b0, 8'h00, 3'd0, 1'b0);
    add(1'b0, 8'h00, 3'd0, 1'b0);
    add(1'b0, 8'h03, 3'd0, 1'b1);
    add(1'b0, 8'h06, 3'd1, 1'b1);
    add(1'b0, 8'h04, 3'd2, 1'b1);
    add(1'b0, 8'h00, 3'd0, 1'b0);
    foreach (tbl[i]) begin
      if (tbl[i].rst) do_reset();
      step(tbl[i].req);
      check($sformatf("vec%0d", i), tbl[i].idx, tbl[i].vld);
    end
    do_reset();
    for (int i = 0; i < 12; i++) begin
      step(8'h03);
`ifdef RR_ARB_TIMEOUT_EN
      check($sformatf("hold2_c%0d", i), 3'((i / 4) % 2), 1'b1);
`else
      check($sformatf("hold2_c%0d", i), 3'd0, 1'b1);
`endif
    end
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(8'h01);
      check($sformatf("hold1_c%0d", i), 3'd0, 1'b1);
    end
    do_reset();
    step(8'h20);
    check("pre_async", 3'd5, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_clear", 3'd0, 1'b0);
    @(posedge clk);
    #1;
    check("async_held", 3'd0, 1'b0);
    #2;
    rst_n = 1'b1;
    step(8'h21);
    check("post_async", 3'd0, 1'b1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/rr_arbiter.md
# rr_arbiter

Round-robin arbiter sharing one resource among `N` requesters. It sits in front of any shared datapath resource, such as a register-file write port or memory port, and drives a registered one-hot grant. The selection core is two instances of the existing `priority_decoder` (lowest set bit wins) applied to rotated-masked and unmasked request vectors. The owner keeps the grant for as long as it holds its request.

## Interface
- `N`, 8, number of requesters; must be ≥2 and a power of two.
- `HOLD_MAX`, 16, maximum consecutive grant cycles per owner; used only when `RR_ARB_TIMEOUT_EN` is defined.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous, active-low.
- `req`  in  N  level request, one bit per requester.
- `gnt`  out  N  one-hot grant, registered.
- `gnt_idx`  out  $clog2(N)  index of the granted requester; 0 when `gnt_valid`=0.
- `gnt_valid`  out  1  high whenever `gnt` != 0.

## Operation
- State machine, two states:
  - IDLE: no owner.
  - GRANT: one owner, stored as `owner_q`.
- Pointer `last_q` holds the index of the most recent owner. Reset value is N-1, so the first arbitration favours bit 0.
- Arbitration function `pick(r, p)`:
  - masked = bits of `r` with index > `p`.
  - If masked != 0, result = lowest set bit of masked.
  - Otherwise, result = lowest set bit of `r`.
  - Empty `r` gives no winner.
- IDLE transitions:
  - If `req` != 0: winner = `pick(req, last_q)`, go to GRANT, `owner_q`=`last_q`=winner.
  - Otherwise stay in IDLE.
- GRANT transitions:
  - If `req[owner_q]`=1 (and no timeout), hold; `gnt` is unchanged.
  - If `req[owner_q]`=0, release: evaluate `pick(req, owner_q)` on the same edge.
    - A winner gives a back-to-back handoff with zero idle cycles.
    - No winner moves to IDLE.
- At most one `gnt` bit is ever high. `gnt_idx` always equals the encoded `gnt`.
- A requester that drops and reasserts `req` while not the owner gets no special treatment.

## Timing
- Reset values:
  - `gnt`=0, `gnt_idx`=0, `gnt_valid`=0.
  - State=IDLE, `last_q`=N-1, hold counter=0.
- Latency:
  - `req` rising in cycle t, with the arbiter in IDLE, produces a grant visible after the edge ending cycle t (1 cycle).
  - Owner `req` falling in cycle t gives a new grant or `gnt`=0 after the same edge.
- The owner must keep `req` high until it has finished with the resource. The grant is released on the edge after `req` drops.
- Wrap-around: with owner N-1, masked is empty, so selection falls back to the lowest set bit.
- Simultaneous release and new requests: the new requests take part in the same edge's `pick`.
- An asynchronous reset mid-grant clears outputs immediately, independent of the clock, and also resets the pointer.

## Configuration
- `RR_ARB_TIMEOUT_EN` defined:
  - A hold counter increments each cycle in GRANT and clears on any owner change.
  - When the counter reaches HOLD_MAX-1 while `req[owner_q]`=1, the arbiter force-releases.
  - On a forced release, `pick` runs on `req` with the `owner_q` bit cleared.
  - If no other requester exists, the owner is re-granted and the counter clears.
  - Worst-case wait per requester: (N-1)·HOLD_MAX cycles.
- `RR_ARB_TIMEOUT_EN` undefined:
  - No counter; the owner holds indefinitely.
  - `HOLD_MAX` is ignored.

## Structure
- Package `arb_pkg`:
  - `arb_state_t` enum {IDLE, GRANT}.
  - Default constants `ARB_N`=8 and `ARB_HOLD_MAX`=16.
- Sub-module `priority_decoder` (WIDTH=N), instantiated twice: one on the masked vector, one on the unmasked vector. Its valid outputs select between the two results.
- Masking, state and counter logic live in `rr_arbiter`.

## Test plan
All scenarios use N=8.
- Reset, then `req`=0 for 5 cycles -> `gnt`=0, `gnt_valid`=0, `gnt_idx`=0 throughout.
- `req`=8'b0101_0000 -> next cycle `gnt_idx`=4. Hold `req[4]` for 3 cycles -> grant unchanged. Drop bit 4 -> next cycle `gnt_idx`=6 with no idle cycle.
- `req`=8'hFF, each owner drops its bit for exactly one cycle after being granted, then reasserts -> grant order 0,1,2,…,7,0.
- Owner 7 with `req`=8'b1000_0010, then bit 7 drops -> `gnt_idx`=1 (wrap). Then bit 1 drops -> `gnt`=0, state IDLE.
- `RR_ARB_TIMEOUT_EN` defined, HOLD_MAX=4, `req`=8'b0000_0011 held high -> `gnt_idx` sequence 0×4, 1×4, 0×4. Same test with only bit 0 set -> grant 0 continuously.
- `rst_n` pulled low mid-cycle while `gnt_idx`=5 -> `gnt`=0 immediately. After release with `req`=8'b0010_0001 -> `gnt_idx`=0.
